// File: rtl/vga_text_fetch_ctrl.sv
// Text-mode character fetch for 8x16 cells: shares the single-port text RAM between
// the display fetch and a CPU port, looks up glyph rows, overlays a blinking cursor.
module vga_text_fetch_ctrl #(
  parameter int unsigned COLS         = 160,
  parameter int unsigned ROWS         = 64,
  parameter int unsigned TRAM_AW      = 14,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               disp,
  input  logic [31:0]        x_pos,
  input  logic [31:0]        y_pos,
  input  logic               vga_hs_in,
  input  logic               vga_vs_in,
  output logic               tram_en,
  output logic               tram_we,
  output logic [TRAM_AW-1:0] tram_addr,
  output logic [7:0]         tram_wdata,
  input  logic [7:0]         tram_rdata,
  output logic [11:0]        font_addr,
  input  logic [7:0]         font_rdata,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [TRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata,
  input  logic               cursor_en,
  input  logic [7:0]         cursor_col,
  input  logic [5:0]         cursor_row,
  output logic               pix_on,
  output logic               disp_out,
  output logic               vga_hs,
  output logic               vga_vs
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

  if (COLS * ROWS > (2 ** TRAM_AW)) begin : g_size_check
    $error("text RAM address width too small for COLS*ROWS");
  end

  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nxt;

  logic [7:0]         col;
  logic [5:0]         row;
  logic               vslot;
  logic [TRAM_AW-1:0] disp_addr;
  logic               cur_hit;
  logic               unused_bits;

  assign col         = x_pos[10:3];
  assign row         = y_pos[9:4];
  assign unused_bits = ^{x_pos[31:11], y_pos[31:10]};
  // Gated by reset so the RAM port stays quiet while reset is held.
  assign vslot       = reset && disp && (x_pos[2:0] == 3'd0);
  assign disp_addr   = TRAM_AW'(32'(row) * COLS + 32'(col));

  logic          vs_prev;
  logic          blink_phase;
  logic [CW-1:0] blink_cnt;

  assign cur_hit = cursor_en && blink_phase && (col == cursor_col) &&
                   (row == cursor_row) && (y_pos[3:0] >= 4'd14);

  always_ff @(posedge clk) begin
    if (!reset) begin
      vs_prev     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= vga_vs_in;
      if (vs_prev && !vga_vs_in) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + CW'(1);
        end
      end
    end
  end

  logic        slot_d1;
  logic [3:0]  line_d1;
  logic [11:0] font_addr_q;
  logic [2:0]  xs_d1, xs_d2;
  logic        hit_d1, hit_d2;
  logic        disp_d1, disp_d2;
  logic        hs_d1, hs_d2;
  logic        vs_d1, vs_d2;

  // RAM data arrives the cycle after the slot; the glyph address is then held for the
  // rest of the cell so the ROM keeps returning the same row for all eight pixels.
  assign font_addr = slot_d1 ? {tram_rdata, line_d1} : font_addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_d1     <= 1'b0;
      line_d1     <= '0;
      font_addr_q <= '0;
      xs_d1       <= '0;
      xs_d2       <= '0;
      hit_d1      <= 1'b0;
      hit_d2      <= 1'b0;
      disp_d1     <= 1'b0;
      disp_d2     <= 1'b0;
      hs_d1       <= 1'b0;
      hs_d2       <= 1'b0;
      vs_d1       <= 1'b0;
      vs_d2       <= 1'b0;
      pix_on      <= 1'b0;
      disp_out    <= 1'b0;
      vga_hs      <= 1'b0;
      vga_vs      <= 1'b0;
    end else begin
      slot_d1     <= vslot;
      line_d1     <= y_pos[3:0];
      font_addr_q <= font_addr;
      xs_d1       <= x_pos[2:0];
      xs_d2       <= xs_d1;
      hit_d1      <= cur_hit;
      hit_d2      <= hit_d1;
      disp_d1     <= disp;
      disp_d2     <= disp_d1;
      hs_d1       <= vga_hs_in;
      hs_d2       <= hs_d1;
      vs_d1       <= vga_vs_in;
      vs_d2       <= vs_d1;
      pix_on      <= (font_rdata[3'd7 - xs_d2] ^ hit_d2) & disp_d2;
      disp_out    <= disp_d2;
      vga_hs      <= hs_d2;
      vga_vs      <= vs_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tram_en    = 1'b0;
    tram_we    = 1'b0;
    tram_addr  = '0;
    tram_wdata = '0;
    cpu_ack    = 1'b0;
    cpu_rdata  = '0;
    if (vslot) begin
      tram_en   = 1'b1;
      tram_addr = disp_addr;
    end
    case (state)
      IDLE: begin
        if (reset && cpu_req && !vslot) begin
          tram_en    = 1'b1;
          tram_we    = cpu_we;
          tram_addr  = cpu_addr;
          tram_wdata = cpu_wdata;
          state_nxt  = ACK;
        end
      end
      ACK: begin
        cpu_ack   = reset;
        cpu_rdata = reset ? tram_rdata : '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
